// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg
// Shared definitions for the loadable instruction memory: loader FSM states,
// stream header length and the default memory depth.
package imem_loader_pkg;

  // Default instruction memory depth in 32-bit words.
  localparam int IM_L_DEFAULT = 16;

  // Number of header bytes carrying the word count N (little-endian).
  localparam int HDR_LEN = 2;

  // Loader FSM states. RUN and ERR are terminal until rst.
  typedef enum logic [2:0] {
    LEN_LO = 3'd0,
    LEN_HI = 3'd1,
    DATA   = 3'd2,
    CSUM   = 3'd3,
    RUN    = 3'd4,
    ERR    = 3'd5
  } ld_state_t;

endpackage

// File: rtl/imem_loader_array.sv
// imem_array
// IM_L x 32 instruction storage with one synchronous write port and one
// asynchronous read port. No reset: contents survive rst so that words
// outside a new image keep their previous values.
// Ports:
//   clk    - write clock
//   we     - write enable, sampled at rising edge
//   waddr  - word write address
//   wdata  - word write data
//   raddr  - word read address
//   rdata  - combinational read data (mem[raddr])
module imem_array
  import imem_loader_pkg::*;
#(
  parameter int IM_L = IM_L_DEFAULT,
  localparam int WW  = $clog2(IM_L)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [WW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [WW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [IM_L];

  // Single write port; a word written at edge k reads back from edge k on.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/imem_loader.sv
// imem_loader
// Loadable instruction memory for the single-cycle RISC-V core. Reads look
// like the instruction ROM (byte address, word returned). A program arrives
// as a valid/ready byte stream: 2 header bytes (word count N, LSB first),
// 4*N data bytes (each word LSB first), then an XOR checksum of the data
// bytes. run is held low until a complete, verified image is resident.
// Ports:
//   clk       - single clock, rising edge
//   rst       - synchronous active-high reset
//   rx_data   - stream byte
//   rx_valid  - rx_data is valid
//   rx_ready  - block accepts a byte this cycle (state decode only)
//   addr      - core instruction byte address (addr[1:0] ignored)
//   oe        - read enable
//   data      - mem[addr>>2] when oe, else 0 (combinational)
//   run       - core run enable, high in RUN
//   done      - image loaded and verified, high in RUN
//   error     - image rejected, high in ERR
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int IM_L = IM_L_DEFAULT,
  localparam int AW  = $clog2(IM_L * 4),
  localparam int WW  = $clog2(IM_L)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    rx_data,
  input  logic          rx_valid,
  output logic          rx_ready,
  input  logic [AW-1:0] addr,
  input  logic          oe,
  output logic [31:0]   data,
  output logic          run,
  output logic          done,
  output logic          error
);

  ld_state_t     state, state_next;
  logic [7:0]    n_lo;
  logic [15:0]   n_words;
  logic [15:0]   n_hdr;
  logic [WW-1:0] word_idx;
  logic [1:0]    byte_cnt;
  logic [7:0]    csum;
  logic [31:0]   asm_word;
  logic [31:0]   asm_next;
  logic          accept;
  logic          len_ok;
  logic          last_word;
  logic          we;
  logic [31:0]   rdata;
  logic [1:0]    unused_addr_lsbs;

  assign accept = rx_valid & rx_ready;

  // Full 16-bit header value; compared at 16 bits so a large N never
  // truncates into the legal range.
  assign n_hdr  = {rx_data, n_lo};
  assign len_ok = (n_hdr >= 16'd1) && (n_hdr <= 16'(IM_L));

  assign last_word = (16'(word_idx) == (n_words - 16'd1));

  // Current byte merged into the assembly register so that the 4th byte of
  // a word is written to memory at the same edge it is accepted.
  always_comb begin
    asm_next = asm_word;
    asm_next[{byte_cnt, 3'b000} +: 8] = rx_data;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= LEN_LO;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and memory write strobe.
  always_comb begin
    state_next = state;
    we         = 1'b0;
    unique case (state)
      LEN_LO: if (accept) state_next = LEN_HI;
      LEN_HI: if (accept) state_next = len_ok ? DATA : ERR;
      DATA: begin
        if (accept && (byte_cnt == 2'd3)) begin
          we = 1'b1;
          if (last_word) state_next = CSUM;
        end
      end
      CSUM: if (accept) state_next = (rx_data == csum) ? RUN : ERR;
      RUN:    state_next = RUN;
      ERR:    state_next = ERR;
      default: state_next = ERR;
    endcase
  end

  // Header latch, word/byte counters, assembly register and checksum.
  always_ff @(posedge clk) begin
    if (rst) begin
      n_lo     <= '0;
      n_words  <= '0;
      word_idx <= '0;
      byte_cnt <= '0;
      csum     <= '0;
      asm_word <= '0;
    end else if (accept) begin
      case (state)
        LEN_LO: n_lo <= rx_data;
        LEN_HI: begin
          n_words  <= n_hdr;
          word_idx <= '0;
          byte_cnt <= '0;
          csum     <= '0;
        end
        DATA: begin
          asm_word <= asm_next;
          csum     <= csum ^ rx_data;
          byte_cnt <= byte_cnt + 2'd1;
          if (byte_cnt == 2'd3) begin
            word_idx <= word_idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  imem_array #(.IM_L(IM_L)) u_array (
    .clk   (clk),
    .we    (we),
    .waddr (word_idx),
    .wdata (asm_next),
    .raddr (addr[AW-1:2]),
    .rdata (rdata)
  );

  // Byte offset within the word is irrelevant for instruction fetch.
  assign unused_addr_lsbs = addr[1:0];

  assign data     = oe ? rdata : 32'b0;
  assign rx_ready = (state == LEN_LO) || (state == LEN_HI) ||
                    (state == DATA)   || (state == CSUM);
  assign run      = (state == RUN);
  assign done     = (state == RUN);
  assign error    = (state == ERR);

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader
// Directed bench for imem_loader (IM_L = 16): valid load, checksum mismatch,
// bad lengths, bubbles, reset mid-load and a full 16-word image.
module tb_imem_loader;

  localparam int IM_L = 16;
  localparam int AW   = $clog2(IM_L * 4);

  logic          clk;
  logic          rst;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic [AW-1:0] addr;
  logic          oe;
  logic [31:0]   data;
  logic          run;
  logic          done;
  logic          error;

  int tests_run = 0;
  int tests_failed = 0;
  int accept_cnt = 0;
  int acc_start;
  logic [31:0] full_words [16];
  logic [7:0]  full_csum;

  imem_loader #(.IM_L(IM_L)) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .addr     (addr),
    .oe       (oe),
    .data     (data),
    .run      (run),
    .done     (done),
    .error    (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts bytes that actually transfer.
  always @(posedge clk) begin
    if (rx_valid && rx_ready) accept_cnt <= accept_cnt + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // One cycle presenting a byte as valid; inputs change #1 after the edge.
  task automatic applyStimulus(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic idleCycle();
    rx_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic doReset();
    rx_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic checkRead(input string tag, input logic [AW-1:0] a,
                           input logic [31:0] expected);
    addr = a;
    oe   = 1'b1;
    #1;
    checkOutput(tag, data, expected);
    oe   = 1'b0;
  endtask

  task automatic sendValidLoad(input bit bubbles);
    logic [7:0] s [11];
    s = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00,
          8'h73, 8'h00, 8'h10, 8'h00, 8'hA0};
    for (int i = 0; i < 11; i++) begin
      if (bubbles) idleCycle();
      applyStimulus(s[i]);
    end
  endtask

  initial begin
    rst = 1'b0; rx_valid = 1'b0; rx_data = '0; addr = '0; oe = 1'b0;
    @(posedge clk); #1;

    // Reset state, checked while rst is still high after the sampling edge.
    rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("rst_ready", 32'(rx_ready), 32'd1);
    checkOutput("rst_run",   32'(run),      32'd0);
    checkOutput("rst_done",  32'(done),     32'd0);
    checkOutput("rst_error", 32'(error),    32'd0);
    rst = 1'b0;

    // Valid load, with a write-latency check on word 0.
    for (int i = 0; i < 6; i++) begin
      logic [7:0] h [6];
      h = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00};
      applyStimulus(h[i]);
    end
    checkRead("w0_visible", 6'd0, 32'h00500093);
    applyStimulus(8'h73); applyStimulus(8'h00);
    applyStimulus(8'h10); applyStimulus(8'h00);
    checkOutput("pre_csum_run", 32'(run), 32'd0);
    applyStimulus(8'hA0);
    checkOutput("valid_run",   32'(run),      32'd1);
    checkOutput("valid_done",  32'(done),     32'd1);
    checkOutput("valid_ready", 32'(rx_ready), 32'd0);
    checkOutput("valid_error", 32'(error),    32'd0);
    checkRead("valid_a0", 6'd0, 32'h00500093);
    checkRead("valid_a4", 6'd4, 32'h00100073);
    checkRead("valid_a5", 6'd5, 32'h00100073);
    addr = 6'd0; oe = 1'b0; #1;
    checkOutput("oe_low_zero", data, 32'h0);

    // Checksum mismatch with different words (correct checksum is 88).
    doReset();
    begin
      logic [7:0] s [11];
      s = '{8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44,
            8'h55, 8'h66, 8'h77, 8'h88, 8'h89};
      for (int i = 0; i < 11; i++) applyStimulus(s[i]);
    end
    checkOutput("bad_csum_error", 32'(error),    32'd1);
    checkOutput("bad_csum_run",   32'(run),      32'd0);
    checkOutput("bad_csum_ready", 32'(rx_ready), 32'd0);
    checkRead("bad_csum_w0", 6'd0, 32'h44332211);
    checkRead("bad_csum_w1", 6'd4, 32'h88776655);

    // Bad lengths: N = 0, N = 17, N = 0x0110 (low byte alone would be 16).
    doReset();
    applyStimulus(8'h00);
    checkOutput("len0_mid_error", 32'(error), 32'd0);
    applyStimulus(8'h00);
    checkOutput("len0_error", 32'(error), 32'd1);
    doReset();
    applyStimulus(8'h11); applyStimulus(8'h00);
    checkOutput("len17_error", 32'(error), 32'd1);
    doReset();
    applyStimulus(8'h10); applyStimulus(8'h01);
    checkOutput("len272_error", 32'(error), 32'd1);
    applyStimulus(8'h5A);
    checkRead("badlen_nowrite", 6'd0, 32'h44332211);

    // Bubbles between every byte.
    doReset();
    acc_start = accept_cnt;
    sendValidLoad(1'b1);
    idleCycle();
    checkOutput("bubble_accepts", 32'(accept_cnt - acc_start), 32'd11);
    checkOutput("bubble_run", 32'(run), 32'd1);
    checkRead("bubble_a0", 6'd0, 32'h00500093);
    checkRead("bubble_a4", 6'd4, 32'h00100073);

    // Reset mid-load after 5 data bytes; word 0 already written persists.
    doReset();
    applyStimulus(8'h03); applyStimulus(8'h00);
    applyStimulus(8'hAA); applyStimulus(8'hBB);
    applyStimulus(8'hCC); applyStimulus(8'hDD);
    applyStimulus(8'hEE);
    doReset();
    checkOutput("midrst_ready", 32'(rx_ready), 32'd1);
    checkOutput("midrst_run",   32'(run),      32'd0);
    checkOutput("midrst_error", 32'(error),    32'd0);
    checkRead("midrst_w0", 6'd0, 32'hDDCCBBAA);
    applyStimulus(8'h01); applyStimulus(8'h00);
    applyStimulus(8'h78); applyStimulus(8'h56);
    applyStimulus(8'h34); applyStimulus(8'h12);
    applyStimulus(8'h08);
    checkOutput("reload_run", 32'(run), 32'd1);
    checkRead("reload_w0", 6'd0, 32'h12345678);
    checkRead("reload_w1_kept", 6'd4, 32'h00100073);

    // Full 16-word image.
    full_csum = 8'h00;
    for (int i = 0; i < 16; i++) begin
      full_words[i] = {8'(8'hC0 + i), 8'(8'h80 + i), 8'(8'h40 + 3 * i), 8'(8'h10 + i)};
      full_csum = full_csum ^ full_words[i][7:0] ^ full_words[i][15:8]
                ^ full_words[i][23:16] ^ full_words[i][31:24];
    end
    doReset();
    applyStimulus(8'h10); applyStimulus(8'h00);
    for (int i = 0; i < 16; i++) begin
      for (int b = 0; b < 4; b++) applyStimulus(full_words[i][b*8 +: 8]);
    end
    checkOutput("full_pre_run", 32'(run), 32'd0);
    applyStimulus(full_csum);
    checkOutput("full_run", 32'(run), 32'd1);
    checkRead("full_a0",  6'd0,  full_words[0]);
    checkRead("full_a60", 6'd60, full_words[15]);
    acc_start = accept_cnt;
    rx_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rx_data = 8'hF0 + 8'(i);
      @(posedge clk); #1;
    end
    rx_valid = 1'b0;
    checkOutput("full_no_accept", 32'(accept_cnt - acc_start), 32'd0);
    checkOutput("full_ready_low", 32'(rx_ready), 32'd0);
    checkOutput("full_still_run", 32'(run), 32'd1);
    checkRead("full_a0_kept",  6'd0,  full_words[0]);
    checkRead("full_a60_kept", 6'd60, full_words[15]);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Loadable instruction memory for the single-cycle RISC-V core. It is a drop-in replacement for the instruction ROM: the core reads it through the same byte-addressed port. The block also accepts a program as a byte stream (valid/ready) and writes it into the memory word by word. It holds the core's `run` low until a complete, checksum-verified image is resident.

## Interface
Parameters:
- `IM_L`, 16: instruction memory depth in 32-bit words; byte address width is `$clog2(IM_L*4)`.

Ports:
- `clk` in 1: single clock. All state changes on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `rx_data` in 8: stream byte.
- `rx_valid` in 1: `rx_data` is valid.
- `rx_ready` out 1: block accepts a byte this cycle. A byte transfers when `rx_valid & rx_ready` at the rising edge.
- `addr` in `$clog2(IM_L*4)`: core instruction byte address. Word index is `addr[msb:2]`; `addr[1:0]` is ignored.
- `oe` in 1: read enable.
- `data` out 32: instruction word. Equals `mem[addr[msb:2]]` when `oe`=1, otherwise 32'b0. Combinational.
- `run` out 1: drives the core's `run` input.
- `done` out 1: image loaded and verified.
- `error` out 1: image rejected.

## Operation
- Stream format, little-endian:
  - 2 header bytes carry `N`, the word count (`N[7:0]` first, then `N[15:8]`).
  - Then `4*N` data bytes; each word is sent LSB first.
  - Then 1 checksum byte, equal to the XOR of all `4*N` data bytes. Header bytes are excluded from the checksum.
- FSM states: `LEN_LO`, `LEN_HI`, `DATA`, `CSUM`, `RUN`, `ERR`.
  - `LEN_LO` → `LEN_HI` on accept; latch `N[7:0]`.
  - `LEN_HI` → on accept, latch `N[15:8]`. If `1 <= N <= IM_L`, go to `DATA` and clear the word index, byte counter and checksum accumulator. Otherwise go to `ERR`.
  - `DATA`: each accept shifts the byte into the word assembly register at `byte_cnt*8` and XORs it into the accumulator.
    - On the 4th byte of a word, `mem[word_idx]` is written at that same edge, using the fully assembled word.
    - Then `word_idx` increments and `byte_cnt` wraps to 0.
    - After the write of word `N-1`, go to `CSUM`.
  - `CSUM` → `RUN` on accept if the byte equals the accumulator; otherwise → `ERR`.
  - `RUN` and `ERR` are terminal; only `rst` leaves them.
- `rx_ready` = 1 in `LEN_LO`, `LEN_HI`, `DATA` and `CSUM`; 0 in `RUN` and `ERR`. It depends only on state, never on `rx_valid`.
- `run` = `done` = (state == `RUN`). `error` = (state == `ERR`). All are registered state decodes.
- Memory is not cleared by reset.
  - Words `N..IM_L-1` keep their previous contents.
  - On a rejected or aborted image, any words already written remain written. `run` stays 0, so the core never executes them.
- Width rules:
  - `word_idx` is `$clog2(IM_L)` bits wide.
  - The `N` comparison is done at 16 bits, so an `N` larger than `IM_L` can never truncate into range.

## Timing
- Reset: state `LEN_LO`, `rx_ready`=1, `run`=0, `done`=0, `error`=0. These values hold from the edge at which `rst` is sampled high.
- Reset mid-load: the load aborts immediately, the next byte is treated as `LEN_LO`, and partial memory writes persist.
- Write latency: a word written at edge k is visible on `data` from edge k onward. A read of the same word in cycle k-1 returns the old value.
- `run` rises at the edge that accepts a matching checksum byte. A minimal load takes `2+4N+1` accepting cycles.
- Bubbles: a cycle with `rx_valid`=0 changes no state.
- The top level ties the core's `rst` to this `rst`, so the core's PC = 0 when `run` rises.

## Structure
- Shared package:
  - loader state enum (`LEN_LO`…`ERR`);
  - header length constant (2 bytes);
  - the default `IM_L`.
- Sub-module `imem_array`: `IM_L` x 32 storage with one synchronous write port (`we`, `waddr`, `wdata`) and one asynchronous read port. The FSM, assembly register, counters and checksum live in `imem_loader`.

## Test plan
- **Valid load.** Stream 02 00, 93 00 50 00, 73 00 10 00, A0.
  - `run`=`done`=1 after the last accept; `rx_ready`=0; `error`=0.
  - `data`@`addr`0 = 0x00500093; `data`@`addr`4 = 0x00100073; `addr`5 also returns 0x00100073.
- **Checksum mismatch.** Same stream with checksum A1 → `error`=1, `run`=0, `rx_ready`=0; the two words are still readable.
- **Bad length.** Header 00 00 → `ERR` after the 2nd byte. Header 11 00 with `IM_L`=16 → `ERR`. No memory write occurs in either case.
- **Bubbles.** Valid-load stream with `rx_valid` toggling every cycle → identical final memory and `run`=1. The byte count accepted equals 11.
- **Reset mid-load.** Assert `rst` after 5 data bytes → next cycle `rx_ready`=1, `run`=0, state `LEN_LO`. A complete reload then succeeds.
- **Full image.** Load `N`=16 → last word at `addr` 60. After `run`, hold `rx_valid`=1 with new bytes → not accepted, and memory is unchanged.
